// File: rtl/hazard_fw_ctrl.sv
// rtl/hazard_fw_ctrl.sv - stall and forwarding-select controller for the 5-stage pipeline
module hazard_fw_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_use,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] D_FW_rs_sel,
  output logic [1:0] D_FW_rt_sel,
  output logic [1:0] E_FW_rs_sel,
  output logic [1:0] E_FW_rt_sel,
  output logic [1:0] M_FW_sel,
  output logic       md_busy
);

  // Shadow copies of the pipeline's destination/source bookkeeping
  logic [4:0] E_rs, E_rt, E_A3;
  logic [1:0] E_Tnew;
  logic       E_md_start, E_md_div;
  logic [4:0] M_rt, M_A3;
  logic [1:0] M_Tnew;
  logic [4:0] W_A3;
  logic [3:0] md_cnt;

  // Register-match terms; address 0 is hardwired zero and never a producer
  logic d_rs_e, d_rs_m, d_rs_w, d_rt_e, d_rt_m, d_rt_w;
  logic e_rs_m, e_rs_w, e_rt_m, e_rt_w, m_rt_w;

  assign d_rs_e = (D_rs != 5'd0) && (D_rs == E_A3);
  assign d_rs_m = (D_rs != 5'd0) && (D_rs == M_A3);
  assign d_rs_w = (D_rs != 5'd0) && (D_rs == W_A3);
  assign d_rt_e = (D_rt != 5'd0) && (D_rt == E_A3);
  assign d_rt_m = (D_rt != 5'd0) && (D_rt == M_A3);
  assign d_rt_w = (D_rt != 5'd0) && (D_rt == W_A3);
  assign e_rs_m = (E_rs != 5'd0) && (E_rs == M_A3);
  assign e_rs_w = (E_rs != 5'd0) && (E_rs == W_A3);
  assign e_rt_m = (E_rt != 5'd0) && (E_rt == M_A3);
  assign e_rt_w = (E_rt != 5'd0) && (E_rt == W_A3);
  assign m_rt_w = (M_rt != 5'd0) && (M_rt == W_A3);

  // Stall when a producer cannot deliver in time, or the MDU is occupied
  always_comb begin
    stall = 1'b0;
    if (d_rs_e && (E_Tnew > D_Tuse_rs)) stall = 1'b1;
    if (d_rs_m && (M_Tnew > D_Tuse_rs)) stall = 1'b1;
    if (d_rt_e && (E_Tnew > D_Tuse_rt)) stall = 1'b1;
    if (d_rt_m && (M_Tnew > D_Tuse_rt)) stall = 1'b1;
    if (D_md_use && ((md_cnt != 4'd0) || E_md_start)) stall = 1'b1;
  end

  // Forwarding selects, youngest ready producer wins
  always_comb begin
    D_FW_rs_sel = 2'd0;
    if (d_rs_e && (E_Tnew == 2'd0))      D_FW_rs_sel = 2'd3;
    else if (d_rs_m && (M_Tnew == 2'd0)) D_FW_rs_sel = 2'd2;
    else if (d_rs_w)                     D_FW_rs_sel = 2'd1;

    D_FW_rt_sel = 2'd0;
    if (d_rt_e && (E_Tnew == 2'd0))      D_FW_rt_sel = 2'd3;
    else if (d_rt_m && (M_Tnew == 2'd0)) D_FW_rt_sel = 2'd2;
    else if (d_rt_w)                     D_FW_rt_sel = 2'd1;

    E_FW_rs_sel = 2'd0;
    if (e_rs_m && (M_Tnew == 2'd0)) E_FW_rs_sel = 2'd2;
    else if (e_rs_w)                E_FW_rs_sel = 2'd1;

    E_FW_rt_sel = 2'd0;
    if (e_rt_m && (M_Tnew == 2'd0)) E_FW_rt_sel = 2'd2;
    else if (e_rt_w)                E_FW_rt_sel = 2'd1;

    M_FW_sel = m_rt_w ? 2'd1 : 2'd0;
  end

  // Advance the shadow pipeline; flush empties E/M/W, stall bubbles E only
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      E_rs       <= 5'd0;
      E_rt       <= 5'd0;
      E_A3       <= 5'd0;
      E_Tnew     <= 2'd0;
      E_md_start <= 1'b0;
      E_md_div   <= 1'b0;
      M_rt       <= 5'd0;
      M_A3       <= 5'd0;
      M_Tnew     <= 2'd0;
      W_A3       <= 5'd0;
    end else begin
      if (stall) begin
        E_rs       <= 5'd0;
        E_rt       <= 5'd0;
        E_A3       <= 5'd0;
        E_Tnew     <= 2'd0;
        E_md_start <= 1'b0;
        E_md_div   <= 1'b0;
      end else begin
        E_rs       <= D_rs;
        E_rt       <= D_rt;
        E_A3       <= D_A3;
        E_Tnew     <= D_Tnew;
        E_md_start <= D_md_start;
        E_md_div   <= D_md_start & D_md_div;
      end
      M_rt   <= E_rt;
      M_A3   <= E_A3;
      M_Tnew <= (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
      W_A3   <= M_A3;
    end
  end

  // MDU busy counter; flush does not abort an operation already issued
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (E_md_start) begin
      md_cnt <= E_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign md_busy = (md_cnt != 4'd0);

endmodule
